// File: rtl/aes_ahb_master.sv
// aes_ahb_master: turns key-load / encrypt requests into single 128-bit AHB-lite
// transfers to the AES slave and returns the ciphertext on a response port.
module aes_ahb_master #(
    parameter logic [31:0] AES_ADDR       = 32'hF0F0_F0F0,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic         HCLK,
    input  logic         HRST,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_key,
    input  logic [127:0] req_data,
    output logic         resp_valid,
    output logic         resp_error,
    output logic [127:0] resp_data,
    output logic [31:0]  HADDR,
    output logic [2:0]   HBURST,
    output logic         HMASTLOCK,
    output logic [3:0]   HPORT,
    output logic [2:0]   HSIZE,
    output logic [1:0]   HTRANS,
    output logic         HWRITE,
    output logic         HSELx,
    output logic [127:0] HWDATA,
    output logic         HREADY,
    input  logic         HRESP,
    input  logic [127:0] HRDATA,
    input  logic         HREADYOUT
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WAIT_DONE,
        S_RD_ADDR,
        S_RD_DATA,
        S_RESP,
        S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_key;
    logic [127:0]       r_data;
    logic [127:0]       r_hwdata;
    logic [127:0]       r_rdata;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_hist;
    logic               w_done;

    // The slave signals completion by a falling edge on HREADYOUT.
    assign w_done = r_hist & ~HREADYOUT;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge HCLK) begin
        if (HRST) begin
            r_state  <= S_IDLE;
            r_key    <= 1'b0;
            r_data   <= '0;
            r_hwdata <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
            r_hist   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_key   <= req_key;
                        r_data  <= req_data;
                        r_rdata <= '0;
                    end
                end
                S_WR_ADDR: begin
                    if (!HRESP) r_hwdata <= r_data;
                end
                S_WR_DATA: begin
                    r_cnt  <= '0;
                    r_hist <= 1'b0;
                end
                S_WAIT_DONE: begin
                    r_hist <= HREADYOUT;
                    if (r_cnt != CNT_LAST) r_cnt <= r_cnt + CNT_W'(1);
                end
                S_RD_DATA: r_rdata <= HRDATA;
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_error = 1'b0;
        HSELx      = 1'b0;
        HTRANS     = 2'b00;
        HWRITE     = 1'b0;
        HREADY     = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = ~HRST;
                if (req_valid) w_next = S_WR_ADDR;
            end
            S_WR_ADDR: begin
                HSELx  = 1'b1;
                HTRANS = 2'b10;
                HWRITE = 1'b1;
                w_next = HRESP ? S_ERR : S_WR_DATA;
            end
            S_WR_DATA: begin
                HSELx  = 1'b1;
                HREADY = 1'b1;
                w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (w_done)                 w_next = r_key ? S_RESP : S_RD_ADDR;
                else if (r_cnt == CNT_LAST) w_next = S_ERR;
            end
            S_RD_ADDR: begin
                HSELx  = 1'b1;
                HTRANS = 2'b10;
                w_next = HRESP ? S_ERR : S_RD_DATA;
            end
            S_RD_DATA: begin
                HSELx  = 1'b1;
                HREADY = 1'b1;
                w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end
            S_ERR: begin
                resp_valid = 1'b1;
                resp_error = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign HADDR     = HSELx ? AES_ADDR : 32'h0;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPORT     = 4'b0000;
    assign HSIZE     = 3'b100;
    assign HWDATA    = r_hwdata;
    // Ciphertext is only presented on a successful response; key loads carry zero.
    assign resp_data = (r_state == S_RESP) ? r_rdata : '0;

endmodule

// File: tb/tb_aes_ahb_master.sv
// tb_aes_ahb_master: randomized transactions against a transaction-level model that
// predicts, from the protocol timing rules, the bus activity and response of each request.
`timescale 1ns/1ps
module tb_aes_ahb_master;

    localparam logic [31:0] ADDR = 32'hF0F0_F0F0;
    localparam int          TO   = 16;

    logic         HCLK = 1'b0;
    logic         HRST;
    logic         req_valid;
    logic         req_ready;
    logic         req_key;
    logic [127:0] req_data;
    logic         resp_valid;
    logic         resp_error;
    logic [127:0] resp_data;
    logic [31:0]  HADDR;
    logic [2:0]   HBURST;
    logic         HMASTLOCK;
    logic [3:0]   HPORT;
    logic [2:0]   HSIZE;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic         HSELx;
    logic [127:0] HWDATA;
    logic         HREADY;
    logic         HRESP;
    logic [127:0] HRDATA;
    logic         HREADYOUT;

    aes_ahb_master #(.AES_ADDR(ADDR), .TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRST(HRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_data(req_data),
        .resp_valid(resp_valid), .resp_error(resp_error), .resp_data(resp_data),
        .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPORT(HPORT), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSELx(HSELx), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRESP(HRESP), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [49:0] w_bus;
    assign w_bus = {HSIZE, HBURST, HPORT, HMASTLOCK, req_ready, resp_valid,
                    HSELx, HTRANS, HWRITE, HREADY, HADDR};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [49:0] exp_bus(input bit ready, input bit rv, input bit sel,
                                            input bit addr_ph, input bit wr, input bit rdy);
        return {3'b100, 3'b000, 4'b0000, 1'b0, ready, rv, sel,
                addr_ph ? 2'b10 : 2'b00, wr, rdy, sel ? ADDR : 32'h0};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One request. drop = cycle (counted from the handshake) at which the slave pulls
    // HREADYOUT low, 0 = never. pre_low holds HREADYOUT low across the data phase and
    // the first wait cycle. hold keeps req_valid high with the next request meanwhile.
    task automatic run_req(input bit key, input logic [127:0] data, input int drop,
                           input bit pre_low, input bit err_wr, input bit err_rd,
                           input logic [127:0] cipher, input bit noise, input bit hold,
                           input bit nkey, input logic [127:0] ndata, input string name);
        int t_wd, t_ra, t_rd, t_resp, n;
        bit exp_err, sel;
        logic [127:0] exp_data;
        t_wd = -1; t_ra = -1; t_rd = -1;
        exp_err = 1'b1; exp_data = '0;
        if (err_wr) begin
            t_resp = 2;
        end else begin
            t_wd = 2;
            if (drop == 0) begin
                t_resp = 3 + TO;
            end else if (key) begin
                t_resp = drop + 1; exp_err = 1'b0;
            end else begin
                t_ra = drop + 1;
                if (err_rd) begin
                    t_resp = drop + 2;
                end else begin
                    t_rd = drop + 2; t_resp = drop + 3;
                    exp_err = 1'b0; exp_data = cipher;
                end
            end
        end

        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        check({name, " accept"}, {127'b0, req_ready}, 128'd1);
        if (req_ready !== 1'b1) return;

        req_valid = 1'b1; req_key = key; req_data = data;
        HREADYOUT = 1'b1; HRESP = noise && ($urandom % 2 == 1); HRDATA = rand128();
        @(posedge HCLK);
        for (int k = 1; k <= t_resp + 1; k++) begin
            @(negedge HCLK);
            if (k == 1) begin
                req_valid = hold;
                req_key   = hold ? nkey : ~key;
                req_data  = hold ? ndata : ~data;
            end
            sel = (k == 1) || (k == t_wd) || (k == t_ra) || (k == t_rd);
            check($sformatf("%s bus k=%0d", name, k), {78'b0, w_bus},
                  {78'b0, exp_bus(k == t_resp + 1, k == t_resp, sel, (k == 1) || (k == t_ra),
                                  k == 1, (k == t_wd) || (k == t_rd))});
            if (k == t_wd) check({name, " hwdata"}, HWDATA, data);
            if (k == t_resp) begin
                check({name, " resp_error"}, {127'b0, resp_error}, {127'b0, exp_err});
                check({name, " resp_data"}, resp_data, exp_data);
            end
            HREADYOUT = !((k == drop) || (pre_low && (k == 2 || k == 3)));
            if (k == 1)         HRESP = err_wr;
            else if (k == t_ra) HRESP = err_rd;
            else                HRESP = noise && ($urandom % 2 == 1);
            HRDATA = (k == t_rd) ? cipher : rand128();
        end
    endtask

    task automatic reset_mid_encrypt();
        req_valid = 1'b1; req_key = 1'b0; req_data = rand128();
        HREADYOUT = 1'b1; HRESP = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        req_valid = 1'b0;
        repeat (4) @(negedge HCLK);
        HRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            check("reset bus", {78'b0, w_bus}, {78'b0, exp_bus(0, 0, 0, 0, 0, 0)});
            check("reset hwdata", HWDATA, 128'd0);
            check("reset resp", {127'b0, resp_error} | resp_data, 128'd0);
        end
        HRST = 1'b0;
        #1;
        check("release ready", {127'b0, req_ready}, 128'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            check("post reset idle", {78'b0, w_bus}, {78'b0, exp_bus(1, 0, 0, 0, 0, 0)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] cd, nd, d1, d2, c1;
        bit ck, nk, hold, pre;
        int drop;

        HRST = 1'b1; req_valid = 1'b0; req_key = 1'b0; req_data = '0;
        HRESP = 1'b0; HRDATA = '0; HREADYOUT = 1'b1;
        repeat (3) @(negedge HCLK);
        check("init reset bus", {78'b0, w_bus}, {78'b0, exp_bus(0, 0, 0, 0, 0, 0)});
        check("init reset hwdata", HWDATA, 128'd0);
        HRST = 1'b0;
        @(negedge HCLK);
        check("init idle", {78'b0, w_bus}, {78'b0, exp_bus(1, 0, 0, 0, 0, 0)});

        run_req(1'b1, 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C, 7, 0, 0, 0, '0, 0, 0, 0, '0, "key");
        run_req(1'b0, 128'h3243F6A8_885A308D_313198A2_E0370734, 9, 0, 0, 0,
                128'h3925841D_02DC09FB_DC118597_196A0B32, 0, 0, 0, '0, "enc");
        run_req(1'b0, rand128(), 7, 0, 1, 0, rand128(), 0, 0, 0, '0, "wr_err");
        run_req(1'b0, rand128(), 0, 0, 0, 0, rand128(), 0, 0, 0, '0, "timeout");
        run_req(1'b0, rand128(), 4, 0, 0, 0, rand128(), 0, 0, 0, '0, "after_to");
        run_req(1'b1, rand128(), 5, 1, 0, 0, '0, 0, 0, 0, '0, "pre_low");
        run_req(1'b0, rand128(), 6, 0, 0, 1, rand128(), 1, 0, 0, '0, "rd_err");
        d1 = rand128(); d2 = rand128(); c1 = rand128();
        run_req(1'b0, d1, 8, 0, 0, 0, c1, 1, 1, 1'b0, d2, "hold1");
        run_req(1'b0, d2, 5, 0, 0, 0, rand128(), 1, 0, 0, '0, "hold2");

        reset_mid_encrypt();

        ck = 1'($urandom % 2); cd = rand128();
        for (int i = 0; i < 40; i++) begin
            nk   = 1'($urandom % 2);
            nd   = rand128();
            hold = (i != 39) && ($urandom % 2 == 1);
            pre  = ($urandom % 3 == 0);
            drop = ($urandom % 8 == 0) ? 0 : $urandom_range(pre ? 5 : 4, 14);
            run_req(ck, cd, drop, pre, $urandom % 10 == 0, $urandom % 10 == 0, rand128(),
                    1, hold, nk, nd, $sformatf("rnd%0d", i));
            ck = nk; cd = nd;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_ahb_master.md
# aes_ahb_master

Upstream AHB-lite master sequencer for the AES slave. It accepts 128-bit key-load and encrypt requests on a simple valid/ready port and converts them into single, non-burst, 128-bit AHB transfers to the AES slave. For an encrypt request it writes the plaintext, waits for the slave to signal completion, reads the ciphertext back, and returns it on a response port. It replaces the hand-driven bus sequencing used during bring-up.

## Interface
- AES_ADDR, 32'hF0F0_F0F0, slave address driven on HADDR
- TIMEOUT_CYCLES, 1024, maximum HCLK cycles spent waiting for slave completion before an error response
- HCLK  in  1  bus clock; the only clock in this block
- HRST  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept a request
- req_key  in  1  1 = key load, 0 = encrypt
- req_data  in  128  key or plaintext
- resp_valid  out  1  one-cycle pulse when a request finishes
- resp_error  out  1  qualifies resp_valid; 1 = HRESP error or timeout
- resp_data  out  128  ciphertext; 0 for key loads and errors
- HADDR  out  32  AES_ADDR while HSELx=1, otherwise 0
- HBURST  out  3  constant 3'b000
- HMASTLOCK  out  1  constant 0
- HPORT  out  4  constant 4'b0000
- HSIZE  out  3  constant 3'b100 (128-bit)
- HTRANS  out  2  2'b10 in an address phase, otherwise 2'b00
- HWRITE  out  1  transfer direction
- HSELx  out  1  slave select
- HWDATA  out  128  write data
- HREADY  out  1  data-phase strobe to the slave
- HRESP  in  1  slave error
- HRDATA  in  128  read data
- HREADYOUT  in  1  slave ready/busy indication

## Operation
- States: IDLE, WR_ADDR, WR_DATA, WAIT_DONE, RD_ADDR, RD_DATA, RESP, ERR.
- IDLE:
  - req_ready=1.
  - When req_valid is high, latch req_key and req_data, then go to WR_ADDR.
- WR_ADDR:
  - Drive HSELx=1, HTRANS=2'b10, HWRITE=1.
  - If HRESP=1 at the end of the cycle, go to ERR; otherwise go to WR_DATA.
- WR_DATA:
  - Drive HSELx=1, HREADY=1, HWDATA=latched data for exactly one cycle.
  - Go to WAIT_DONE, clear the timeout counter, and clear the stored previous HREADYOUT value.
- WAIT_DONE:
  - All bus outputs are idle.
  - Each cycle, register HREADYOUT into a one-bit history.
  - A 1→0 transition (history=1, current=0) means the slave has finished.
  - On completion, a key load goes to RESP and an encrypt goes to RD_ADDR.
  - When the counter reaches TIMEOUT_CYCLES-1 without completion, go to ERR.
- RD_ADDR:
  - Drive HSELx=1, HTRANS=2'b10, HWRITE=0.
  - If HRESP=1, go to ERR; otherwise go to RD_DATA.
- RD_DATA:
  - Drive HSELx=1, HREADY=1.
  - Capture HRDATA into resp_data at the end of the cycle, then go to RESP.
- RESP: resp_valid=1, resp_error=0 for one cycle, then go to IDLE.
- ERR: resp_valid=1, resp_error=1, resp_data=0 for one cycle, then go to IDLE.
- Timeout counter width is $clog2(TIMEOUT_CYCLES). It saturates and never wraps.
- Idle bus values: HSELx=0, HTRANS=2'b00, HREADY=0, HWRITE=0, HADDR=0. HWDATA holds its last value.
- A request arriving while req_ready=0 is ignored and must be held by the requester.
- The bus is never released in the middle of a transfer. No new request is accepted in RESP or ERR.

## Timing
- While HRST=1 at a rising edge:
  - state is set to IDLE.
  - All outputs are set to 0, except the constants: HSIZE=3'b100, HBURST=0, HPORT=0, HMASTLOCK=0.
  - The timeout counter, history bit and latched data are cleared.
  - HRST asserted mid-operation aborts the transfer immediately with no response pulse.
- Handshake in cycle N (req_valid & req_ready):
  - WR_ADDR in N+1, WR_DATA in N+2, WAIT_DONE from N+3.
- Key load: with completion detected in cycle M, resp_valid is asserted in M+1.
- Encrypt: with completion detected in cycle M, RD_ADDR is in M+1, RD_DATA in M+2, and resp_valid with the ciphertext in M+3.
- Minimum encrypt latency from request to response is 6 cycles plus the slave processing time.
- If HREADYOUT is already 0 on entry to WAIT_DONE, completion requires a full 0→1→0 sequence.
- If HRESP is asserted together with the address phase it is sampled in that same cycle. HRESP in any other state is ignored.

## Test plan
- Reset: hold HRST=1 for 3 cycles mid-encrypt → all outputs 0 except constants, req_ready=1 on the first cycle after release, no resp_valid.
- Key load with req_data=128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C and a slave model that drops HREADYOUT 5 cycles after the data phase:
  - one write with HADDR=F0F0F0F0, HSIZE=100, HTRANS=10, HWDATA equal to the key.
  - resp_valid=1 with resp_error=0 and resp_data=0 one cycle after the HREADYOUT fall.
- Encrypt with plaintext 128'h3243F6A8_885A308D_313198A2_E0370734 after the key load above; slave returns HRDATA=128'h3925841D_02DC09FB_DC118597_196A0B32:
  - write, then read with HWRITE=0.
  - resp_data equals the ciphertext on the resp_valid cycle, 3 cycles after completion.
- HRESP=1 during WR_ADDR → no data phase (HREADY never asserted), resp_valid=1 with resp_error=1 on the next cycle, then req_ready=1.
- Slave never drops HREADYOUT, with TIMEOUT_CYCLES=16 → resp_error=1 exactly 16 cycles after entering WAIT_DONE; the next request completes normally.
- req_valid held high during a busy encrypt → no second acceptance until the cycle after resp_valid; the second request's data is unchanged on HWDATA.
